fir_sym_tx: RTL and testbench

Pulse-shaping symbol transmitter: the sending end of the 9-tap matched-filter detector's sample stream. It accepts one data bit per symbol over a valid/ready handshake. For each bit it emits a 9-sample, 4-bit pulse built from the same coefficient set the detector uses, time-reversed so that the detector's sum peaks at the last sample. An optional run of idle zero samples follows each pulse. Its x output drives the detector's x input directly, one sample per clock.

---
 rtl/fir_sym_tx.sv | 125 ++++++++++++
 tb/tb_fir_sym_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sym_tx.sv
// Pulse-shaping symbol transmitter: emits a time-reversed TAPS-sample pulse per bit,
// plus gap_len idle samples. Ports: clk, rst_n, bit_in/bit_valid/bit_ready, c, gap_len, x, x_valid, sym_start, sym_cnt.
module fir_sym_tx #(
  parameter int TAPS = 9,
  parameter int W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  input  logic [TAPS-1:0][W-1:0]   c,
  input  logic [3:0]               gap_len,
  output logic [W-1:0]             x,
  output logic                     x_valid,
  output logic                     sym_start,
  output logic [15:0]              sym_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(TAPS - 1);

  state_t                   state_q;
  logic [3:0]               idx_q;
  logic [3:0]               gcnt_q;
  logic [3:0]               gap_q;
  logic                     bit_q;
  logic [TAPS-1:0][W-1:0]   c_q;

  logic                     last_send;
  logic                     xfer;
  logic [3:0]               rd_idx;
  logic [W-1:0]             send_x_d;

  assign last_send = (state_q == SEND) && (idx_q == LAST);

  // Ready on the last visible sample of a symbol so the next
  // pulse can follow without a bubble.
  assign bit_ready = (state_q == IDLE)
                   | (last_send && (gap_q == 4'd0))
                   | ((state_q == GAP) && (gcnt_q == gap_q));

  assign xfer = bit_valid & bit_ready;

  // Next sample is c_snap[TAPS-1-(idx+1)]; guarded at the last index.
  always_comb begin
    rd_idx   = 4'd0;
    send_x_d = '0;
    if (idx_q != LAST) begin
      rd_idx = LAST - (idx_q + 4'd1);
    end
    if (bit_q) begin
      send_x_d = c_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      gcnt_q    <= 4'd0;
      gap_q     <= 4'd0;
      bit_q     <= 1'b0;
      c_q       <= '0;
      x         <= '0;
      x_valid   <= 1'b0;
      sym_start <= 1'b0;
      sym_cnt   <= 16'd0;
    end else if (xfer) begin
      state_q   <= SEND;
      bit_q     <= bit_in;
      c_q       <= c;
      gap_q     <= gap_len;
      idx_q     <= 4'd0;
      gcnt_q    <= 4'd0;
      sym_cnt   <= sym_cnt + 16'd1;
      x         <= bit_in ? c[LAST] : '0;
      x_valid   <= 1'b1;
      sym_start <= 1'b1;
    end else begin
      case (state_q)
        SEND: begin
          sym_start <= 1'b0;
          if (idx_q != LAST) begin
            idx_q <= idx_q + 4'd1;
            x     <= send_x_d;
          end else if (gap_q != 4'd0) begin
            state_q <= GAP;
            gcnt_q  <= 4'd1;
            x       <= '0;
          end else begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            x       <= '0;
            x_valid <= 1'b0;
          end
        end
        GAP: begin
          x         <= '0;
          sym_start <= 1'b0;
          if (gcnt_q != gap_q) begin
            gcnt_q <= gcnt_q + 4'd1;
          end else begin
            state_q <= IDLE;
            gcnt_q  <= 4'd0;
            idx_q   <= 4'd0;
            x_valid <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          x         <= '0;
          x_valid   <= 1'b0;
          sym_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sym_tx.sv
// Testbench for fir_sym_tx: vector table, scoreboard queue,
// back-to-back, mid-symbol reset and detector model sequences.
module tb_fir_sym_tx;

  localparam int TAPS = 9;
  localparam int W    = 4;

  typedef logic [TAPS-1:0][W-1:0] coef_t;

  typedef struct {
    logic       b;
    logic [3:0] gap;
    int         cpat;
    logic [3:0] exp_first;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [W-1:0] x;
    logic         ss;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  coef_t         c;
  logic [3:0]    gap_len;
  logic [W-1:0]  x;
  logic          x_valid;
  logic          sym_start;
  logic [15:0]   sym_cnt;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  logic [W-1:0] xr [TAPS];
  coef_t        det_c;
  int           thresh;

  fir_sym_tx #(.TAPS(TAPS), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .c         (c),
    .gap_len   (gap_len),
    .x         (x),
    .x_valid   (x_valid),
    .sym_start (sym_start),
    .sym_cnt   (sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic coef_t mkc(input int p);
    coef_t r;
    for (int i = 0; i < TAPS; i++) begin
      case (p)
        0:       r[i] = W'(i + 1);
        1:       r[i] = W'(15);
        2:       r[i] = W'(15 - i);
        default: r[i] = '0;
      endcase
    end
    return r;
  endfunction

  task automatic push_sym(input logic b, input logic [3:0] g,
                          input coef_t cc);
    exp_t e;
    for (int j = 0; j < TAPS; j++) begin
      e.x  = b ? cc[TAPS-1-j] : '0;
      e.ss = (j == 0);
      q.push_back(e);
    end
    for (int j = 0; j < int'(g); j++) begin
      e.x  = '0;
      e.ss = 1'b0;
      q.push_back(e);
    end
  endtask

  // Scoreboard: every valid sample must match the next queued one.
  always @(negedge clk) begin
    if (rst_n && x_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_sample", 32'(x_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sample_x", 32'(x), 32'(e.x));
        chk("sample_ss", 32'(sym_start), 32'(e.ss));
      end
    end
  end

  // Behavioral matched-filter detector fed by x.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) xr[k] <= '0;
    end else begin
      xr[0] <= x;
      for (int k = 1; k < TAPS; k++) xr[k] <= xr[k-1];
    end
  end

  function automatic logic det_y();
    int s;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += int'(xr[k]) * int'(det_c[k]);
    return s >= thresh;
  endfunction

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bit_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_check(input string name, input logic [15:0] ecnt);
    @(negedge clk);
    chk({name, "_xv_idle"}, 32'(x_valid), 32'd0);
    chk({name, "_q_empty"}, 32'(q.size()), 32'd0);
    chk({name, "_cnt"}, 32'(sym_cnt), 32'(ecnt));
    q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    coef_t cc;
    logic ok;
    int L;
    cc = mkc(v.cpat);
    L  = TAPS + int'(v.gap);
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    c         = cc;
    gap_len   = v.gap;
    bit_in    = v.b;
    bit_valid = 1'b1;
    push_sym(v.b, v.gap, cc);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bit_valid = 1'b0;
        chk("first_x", 32'(x), 32'(v.exp_first));
        c       = '0;
        gap_len = 4'd0;
      end
      chk("xv_in_sym", 32'(x_valid), 32'd1);
      chk("ready_pos", 32'(bit_ready), 32'(k == L));
    end
    idle_check("vec", v.exp_cnt);
  endtask

  task automatic e2e(input int cpat, input int th);
    coef_t cc;
    int yc;
    int yk;
    logic ok;
    cc     = mkc(cpat);
    det_c  = cc;
    thresh = th;
    yc = 0;
    yk = -1;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    c         = cc;
    gap_len   = 4'd0;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    push_sym(1'b1, 4'd0, cc);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (det_y()) begin
        yc++;
        yk = k;
      end
      if (k == 9) begin
        chk("e2e_ready9", 32'(bit_ready), 32'd1);
        bit_in = 1'b0;
        push_sym(1'b0, 4'd0, cc);
      end
      if (k == 10) bit_valid = 1'b0;
    end
    chk("e2e_y_count", 32'(yc), 32'd1);
    chk("e2e_y_cycle", 32'(yk), 32'd10);
    chk("e2e_q_empty", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    vec_t tbl [6];
    logic ok;
    tbl[0] = '{b: 1'b1, gap: 4'd0,  cpat: 0, exp_first: 4'd9,  exp_cnt: 16'd1};
    tbl[1] = '{b: 1'b0, gap: 4'd0,  cpat: 0, exp_first: 4'd0,  exp_cnt: 16'd2};
    tbl[2] = '{b: 1'b1, gap: 4'd3,  cpat: 0, exp_first: 4'd9,  exp_cnt: 16'd3};
    tbl[3] = '{b: 1'b1, gap: 4'd1,  cpat: 2, exp_first: 4'd7,  exp_cnt: 16'd4};
    tbl[4] = '{b: 1'b0, gap: 4'd2,  cpat: 1, exp_first: 4'd0,  exp_cnt: 16'd5};
    tbl[5] = '{b: 1'b1, gap: 4'd15, cpat: 1, exp_first: 4'd15, exp_cnt: 16'd6};

    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    c         = '0;
    gap_len   = 4'd0;
    det_c     = '0;
    thresh    = 1;
    #23;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_xv", 32'(x_valid), 32'd0);
    chk("rst_ss", 32'(sym_start), 32'd0);
    chk("rst_cnt", 32'(sym_cnt), 32'd0);
    chk("rst_ready", 32'(bit_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-symbol reset on the 4th sample.
    @(negedge clk);
    c         = mkc(0);
    gap_len   = 4'd0;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    push_sym(1'b1, 4'd0, mkc(0));
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_x4", 32'(x), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_xv", 32'(x_valid), 32'd0);
    chk("mid_rst_cnt", 32'(sym_cnt), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_xv", 32'(x_valid), 32'd0);
      chk("post_rst_ready", 32'(bit_ready), 32'd1);
    end

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Back-to-back with coefficient changes during the first symbol.
    @(negedge clk);
    wait_ready(ok);
    c         = mkc(1);
    gap_len   = 4'd0;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    push_sym(1'b1, 4'd0, mkc(1));
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 2) c = '0;
      if (k == 8) c = mkc(1);
      if (k == 9) push_sym(1'b1, 4'd0, mkc(1));
      if (k == 10) bit_valid = 1'b0;
      chk("b2b_xv", 32'(x_valid), 32'd1);
      chk("b2b_ready", 32'(bit_ready), 32'(k == 9 || k == 18));
    end
    idle_check("b2b", 16'd8);

    e2e(1, 2025);
    e2e(0, 285);
    idle_check("end", 16'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
